// File: rtl/rram_page_buffer.sv
// rram_page_buffer: 32-byte page buffer between a strobed host port and an RRAM array.
// Define PB_PARITY_EN to add dout_par, the registered even parity of dout.
module rram_page_buffer #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CE,
  input  logic          RE,
  input  logic          WE,
  input  logic [DW-1:0] din,
  input  logic          load,
  input  logic          flush,
  input  logic [DW-1:0] arr_data,
  output logic [AW-1:0] arr_add,
  output logic          arr_rd,
  output logic          arr_wr,
  output logic [DW-1:0] arr_wdata,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          page_full
`ifdef PB_PARITY_EN
  ,
  output logic          dout_par
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] READY = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

  logic [1:0]    state;
  logic [DW-1:0] page [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   seq;
  logic          re_d;
  logic          we_d;
  logic          cap_vld;
  logic [AW-1:0] cap_add;

  logic          re_fall;
  logic          we_rise;
  logic          idle_rdy;
  logic          host_ok;
  logic          start_load;
  logic          start_flush;
  logic          do_read;
  logic          do_write;
  logic [AW-1:0] nxt_add;

  assign re_fall  = re_d & ~RE;
  assign we_rise  = ~we_d & WE;
  assign idle_rdy = (state == IDLE) || (state == READY);
  assign busy     = (state == LOAD) || (state == FLUSH);
  assign host_ok  = ~CE & ~busy;
  assign page_full = (count == FULL);
  assign nxt_add  = arr_add + 1'b1;

  // load beats flush; both beat host strobes in the same cycle
  assign start_load  = load & idle_rdy;
  assign start_flush = flush & ~load & (state == READY);

  assign do_read = host_ok & re_fall & (state == READY)
                 & ~start_load & ~start_flush;

  assign do_write = host_ok & we_rise & ~do_read & idle_rdy
                  & (count < FULL) & ~start_load & ~start_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      seq       <= '0;
      dout      <= '0;
      arr_add   <= '0;
      arr_rd    <= 1'b0;
      arr_wr    <= 1'b0;
      arr_wdata <= '0;
      re_d      <= 1'b1;
      we_d      <= 1'b1;
      cap_vld   <= 1'b0;
      cap_add   <= '0;
`ifdef PB_PARITY_EN
      dout_par  <= 1'b0;
`endif
    end else begin
      re_d    <= RE;
      we_d    <= WE;
      cap_vld <= arr_rd;
      cap_add <= arr_add;
      unique case (state)
        IDLE, READY: begin
          if (start_load) begin
            state   <= LOAD;
            arr_rd  <= 1'b1;
            arr_add <= '0;
            seq     <= '0;
          end else if (start_flush) begin
            state     <= FLUSH;
            arr_wr    <= 1'b1;
            arr_add   <= '0;
            arr_wdata <= page[0];
            seq       <= '0;
          end else if (do_read) begin
            dout   <= page[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
`ifdef PB_PARITY_EN
            dout_par <= ^page[rd_ptr];
`endif
          end else if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
            if (count == LAST) state <= READY;
          end
        end
        LOAD: begin
          seq <= seq + 1'b1;
          if (seq == LAST) begin
            arr_rd <= 1'b0;
          end else if (seq < LAST) begin
            arr_add <= nxt_add;
          end
          // last byte lands one cycle after the final read strobe
          if (seq == FULL) begin
            state   <= READY;
            arr_add <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= FULL;
          end
        end
        FLUSH: begin
          seq <= seq + 1'b1;
          if (seq == LAST) begin
            state     <= IDLE;
            arr_wr    <= 1'b0;
            arr_add   <= '0;
            arr_wdata <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
          end else begin
            arr_add   <= nxt_add;
            arr_wdata <= page[nxt_add];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // page storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (cap_vld && state == LOAD) begin
      page[cap_add] <= arr_data;
    end else if (do_write) begin
      page[wr_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_rram_page_buffer.sv
// tb_rram_page_buffer: scoreboard bench for rram_page_buffer.
// The array model returns data equal to the address one cycle after arr_rd.
module tb_rram_page_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CE = 1'b0;
  logic       RE = 1'b1;
  logic       WE = 1'b1;
  logic [7:0] din = '0;
  logic       load = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] arr_data = '0;
  logic [4:0] arr_add;
  logic       arr_rd;
  logic       arr_wr;
  logic [7:0] arr_wdata;
  logic [7:0] dout;
  logic       busy;
  logic       page_full;
`ifdef PB_PARITY_EN
  logic       dout_par;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  rram_page_buffer dut (
    .clk(clk),
    .rst(rst),
    .CE(CE),
    .RE(RE),
    .WE(WE),
    .din(din),
    .load(load),
    .flush(flush),
    .arr_data(arr_data),
    .arr_add(arr_add),
    .arr_rd(arr_rd),
    .arr_wr(arr_wr),
    .arr_wdata(arr_wdata),
    .dout(dout),
    .busy(busy),
    .page_full(page_full)
`ifdef PB_PARITY_EN
    ,
    .dout_par(dout_par)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arr_rd) arr_data <= {3'b000, arr_add};
  end

  task automatic re_pulse();
    RE = 1'b0;
    @(negedge clk);
    RE = 1'b1;
    @(negedge clk);
  endtask

  task automatic we_pulse(input logic [7:0] d);
    WE = 1'b0;
    @(negedge clk);
    din = d;
    WE = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({arr_rd, arr_wr, busy, page_full} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl got %b want 0000",
               {arr_rd, arr_wr, busy, page_full});
    end
    total++;
    if ({dout, arr_wdata, arr_add} !== 21'd0) begin
      bad++;
      $display("FAIL reset_data got %h/%h/%h want 0",
               dout, arr_wdata, arr_add);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dut.count !== 6'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_cnt got %0d/%b want 0/0", dut.count, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (arr_rd !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midload_pre got rd=%b busy=%b want 1/1", arr_rd, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (arr_rd !== 1'b0 || dut.state !== 2'd0) begin
      bad++;
      $display("FAIL midload_abort got rd=%b st=%0d want 0/0",
               arr_rd, dut.state);
    end
    total++;
    if ({arr_wr, busy, page_full, dout, arr_wdata, arr_add} !== 24'd0) begin
      bad++;
      $display("FAIL midload_outs got %h want 0",
               {arr_wr, busy, page_full, dout, arr_wdata, arr_add});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (arr_rd !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midload_post got rd=%b busy=%b want 0/0", arr_rd, busy);
    end
  endtask

  task automatic test_write_flush();
    int n;
    int k;
    for (int i = 0; i < 32; i++) begin
      we_pulse(8'hA0 + 8'(i));
      exp_q.push_back(8'hA0 + 8'(i));
      if (i == 30) begin
        total++;
        if (page_full !== 1'b0) begin
          bad++;
          $display("FAIL full_early got %b want 0", page_full);
        end
      end
    end
    total++;
    if (page_full !== 1'b1) begin
      bad++;
      $display("FAIL full_set got %b want 1", page_full);
    end
    we_pulse(8'h55);
    total++;
    if (dut.count !== 6'd32 || page_full !== 1'b1) begin
      bad++;
      $display("FAIL full_ignore got cnt=%0d want 32", dut.count);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    k = 0;
    while (k < 40) begin
      if (arr_wr) begin
        e = exp_q.pop_front();
        total++;
        if (arr_wdata !== e || arr_add !== 5'(n)) begin
          bad++;
          $display("FAIL flush_beat%0d got %h@%0d want %h@%0d",
                   n, arr_wdata, arr_add, e, n);
        end
        n++;
      end
      k++;
      @(negedge clk);
    end
    total++;
    if (n !== 32 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL flush_len got %0d want 32", n);
    end
    total++;
    if (dut.count !== 6'd0 || busy !== 1'b0 || page_full !== 1'b0) begin
      bad++;
      $display("FAIL flush_end got cnt=%0d busy=%b want 0/0",
               dut.count, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_load();
    int n;
    int r;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    r = 0;
    while (busy && n < 60) begin
      if (arr_rd) begin
        total++;
        if (arr_add !== 5'(r)) begin
          bad++;
          $display("FAIL load_add got %0d want %0d", arr_add, r);
        end
        r++;
      end
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== 33 || r !== 32) begin
      bad++;
      $display("FAIL load_len got busy=%0d rd=%0d want 33/32", n, r);
    end
    total++;
    if (page_full !== 1'b1) begin
      bad++;
      $display("FAIL load_full got %b want 1", page_full);
    end
    for (int i = 0; i < 33; i++) begin
      exp_q.push_back(8'(i % 32));
      re_pulse();
      e = exp_q.pop_front();
      total++;
      if (dout !== e) begin
        bad++;
        $display("FAIL read%0d got %h want %h", i, dout, e);
      end
`ifdef PB_PARITY_EN
      total++;
      if (dout_par !== ^e) begin
        bad++;
        $display("FAIL par%0d got %b want %b", i, dout_par, ^e);
      end
`endif
    end
  endtask

  task automatic test_ce_and_collision();
    CE = 1'b1;
    repeat (3) re_pulse();
    total++;
    if (dout !== 8'h00 || dut.rd_ptr !== 5'd1) begin
      bad++;
      $display("FAIL ce_hold got %h/%0d want 00/1", dout, dut.rd_ptr);
    end
    CE = 1'b0;
    WE = 1'b0;
    @(negedge clk);
    din = 8'h99;
    WE = 1'b1;
    RE = 1'b0;
    @(negedge clk);
    RE = 1'b1;
    @(negedge clk);
    total++;
    if (dout !== 8'h01 || dut.rd_ptr !== 5'd2) begin
      bad++;
      $display("FAIL collide_rd got %h/%0d want 01/2", dout, dut.rd_ptr);
    end
    total++;
    if (dut.count !== 6'd32) begin
      bad++;
      $display("FAIL collide_cnt got %0d want 32", dut.count);
    end
  endtask

  task automatic test_load_flush_same();
    int n;
    int w;
    load = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    load = 1'b0;
    flush = 1'b0;
    total++;
    if (arr_rd !== 1'b1 || arr_wr !== 1'b0) begin
      bad++;
      $display("FAIL lf_prio got rd=%b wr=%b want 1/0", arr_rd, arr_wr);
    end
    n = 0;
    w = 0;
    while (busy && n < 60) begin
      if (arr_wr) w++;
      n++;
      @(negedge clk);
    end
    total++;
    if (w !== 0 || n !== 33) begin
      bad++;
      $display("FAIL lf_run got wr=%0d busy=%0d want 0/33", w, n);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_write_flush();
    test_load();
    test_ce_and_collision();
    test_load_flush_same();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
